// File: rtl/memory_arbiter_n.sv
// -----------------------------------------------------------------------------
// memory_arbiter_n
//   Shares one single-ported RAM between NUM_PORTS requesters. Each transaction
//   runs IDLE (grant) -> ACCESS (held while ram_busy) -> RESP (one-cycle ready).
//   Winner selection is fixed priority (lowest index) or round-robin.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   req_ren/req_wen   per-port read / write request (both high = write)
//   req_addr          per-port address, port k at [k*ADDR_W +: ADDR_W]
//   req_store         per-port write data, packed the same way
//   req_ready         one-hot completion pulse, valid in RESP
//   req_load          read data of the last completed read
//   grant_id          index of the port owning the RAM
//   ram_ren/ram_wen   RAM strobes, asserted only in ACCESS
//   ram_addr/ram_store latched address / write data of the current owner
//   ram_load          RAM read data, valid when ram_busy is low
//   ram_busy          RAM still working; low = access completes this cycle
// -----------------------------------------------------------------------------
module memory_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_MODE   = 0,
  localparam int ID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_PORTS-1:0]        req_ren,
  input  logic [NUM_PORTS-1:0]        req_wen,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_store,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [DATA_W-1:0]           req_load,
  output logic [ID_W-1:0]             grant_id,
  output logic                        ram_ren,
  output logic                        ram_wen,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_store,
  input  logic [DATA_W-1:0]           ram_load,
  input  logic                        ram_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]           state_q,  state_d;
  logic [ID_W-1:0]      grant_q,  grant_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;   // last granted port
  logic                 wr_q,     wr_d;
  logic [ADDR_W-1:0]    addr_q,   addr_d;
  logic [DATA_W-1:0]    store_q,  store_d;
  logic [DATA_W-1:0]    load_q,   load_d;

  logic [NUM_PORTS-1:0] req_any;
  logic                 win_valid;
  logic [ID_W-1:0]      win_id;

  assign req_any = req_ren | req_wen;

  // Winner selection. Both loops run from the least preferred candidate to the
  // most preferred one, so the last hit overwrites the others and no early
  // exit is needed.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    win_valid = 1'b0;
    win_id    = '0;
    if (RR_MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req_any[ID_W'(i)]) begin
          win_valid = 1'b1;
          win_id    = ID_W'(i);
        end
      end
    end else begin
      // Search order starts just after the last grant and wraps around.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        if (req_any[ID_W'((int'(rr_ptr_q) + k) % NUM_PORTS)]) begin
          win_valid = 1'b1;
          win_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    store_d  = store_q;
    load_d   = load_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d  = S_ACCESS;
          grant_d  = win_id;
          rr_ptr_d = win_id;
          // A simultaneous read+write request is a write.
          wr_d     = req_wen[win_id];
          addr_d   = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
          store_d  = req_store[int'(win_id)*DATA_W +: DATA_W];
        end
      end
      S_ACCESS: begin
        if (!ram_busy) begin
          if (!wr_q) load_d = ram_load;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (RST) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= ID_W'(NUM_PORTS - 1);  // port 0 searched first after reset
      wr_q     <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      load_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      load_q   <= load_d;
    end
  end

  // All outputs decode registered state only, so they are glitch-free and
  // independent of same-cycle requester activity.
  assign ram_ren   = (state_q == S_ACCESS) && !wr_q;
  assign ram_wen   = (state_q == S_ACCESS) &&  wr_q;
  assign ram_addr  = addr_q;
  assign ram_store = store_q;
  assign req_load  = load_q;
  assign grant_id  = grant_q;

  always_comb begin
    req_ready = '0;
    if (state_q == S_RESP) req_ready[grant_q] = 1'b1;
  end

endmodule
